wash_phase_timer: RTL and testbench



---
 rtl/wash_phase_timer.sv | 131 +++++++++++++
 tb/tb_wash_phase_timer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/wash_phase_timer.sv
// Phase timer for the washing-machine controller: times each phase code, pulses Time_Event
// on expiry and freezes a paused spin. Define WASH_TIMER_FAST_SIM_EN to bypass the prescaler.
module wash_phase_timer #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int FILL_SEC      = 60,
    parameter int WASH_SEC      = 300,
    parameter int RINSE_SEC     = 120,
    parameter int SPIN_SEC      = 60,
    parameter int SEC_W         = 10
) (
    input  logic             Clk_D,
    input  logic             Rst,
    input  logic [2:0]       Timer_Encoding,
    input  logic             Pause_Enable,
    output logic             Time_Event,
    output logic [SEC_W-1:0] Remaining_Sec,
    output logic             Paused
);

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_RINSE = 3'd3,
        PH_SPIN  = 3'd4
    } phase_e;

`ifdef WASH_TIMER_FAST_SIM_EN
    localparam int TICKS = 1;
`else
    localparam int TICKS = TICKS_PER_SEC;
`endif
    localparam int PW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS - 1);
    // The entry cycle is the first cycle of the first second, so the prescaler starts one step in;
    // with a single tick per second that first second already elapses in the entry cycle.
    localparam logic [PW-1:0]    PRESC_ENTRY = (TICKS > 1) ? PW'(1'b1) : PW'(1'b0);
    localparam logic [SEC_W-1:0] ENTRY_ADJ   = (TICKS > 1) ? {SEC_W{1'b0}} : SEC_W'(1'b1);

    function automatic logic [SEC_W-1:0] dur_of(input phase_e ph);
        case (ph)
            PH_FILL:  dur_of = SEC_W'(FILL_SEC);
            PH_WASH:  dur_of = SEC_W'(WASH_SEC);
            PH_RINSE: dur_of = SEC_W'(RINSE_SEC);
            PH_SPIN:  dur_of = SEC_W'(SPIN_SEC);
            default:  dur_of = {SEC_W{1'b0}};
        endcase
    endfunction

    phase_e           code_s;
    phase_e           prev_code_r;
    logic [PW-1:0]    presc_r;
    logic [SEC_W-1:0] rem_r;
    logic [SEC_W-1:0] dur_s;
    logic             paused_r;
    logic             time_event_r;
    logic             entry_s;
    logic             resume_s;
    logic             pause_s;
    logic             tick_s;
    logic             entry_event_s;

    // Map the raw phase code onto a known phase; unused codes behave as IDLE.
    always_comb begin
        code_s = PH_IDLE;
        case (Timer_Encoding)
            3'd1:    code_s = PH_FILL;
            3'd2:    code_s = PH_WASH;
            3'd3:    code_s = PH_RINSE;
            3'd4:    code_s = PH_SPIN;
            default: code_s = PH_IDLE;
        endcase
    end

    // Entry, resume, pause and prescaler-wrap qualifiers for the current cycle.
    always_comb begin
        dur_s         = dur_of(code_s);
        entry_s       = (code_s != PH_IDLE) && (code_s != prev_code_r);
        resume_s      = entry_s && (code_s == PH_SPIN) && paused_r;
        pause_s       = (code_s == PH_SPIN) && Pause_Enable && !time_event_r &&
                        (rem_r != {SEC_W{1'b0}}) && !paused_r && !entry_s;
        tick_s        = (presc_r == PRESC_LAST);
        entry_event_s = (ENTRY_ADJ != {SEC_W{1'b0}}) && (dur_s == SEC_W'(1'b1));
    end

    // Phase timer state: load on entry, freeze on pause, count down otherwise.
    always_ff @(posedge Clk_D or negedge Rst) begin
        if (!Rst) begin
            prev_code_r  <= PH_IDLE;
            presc_r      <= {PW{1'b0}};
            rem_r        <= {SEC_W{1'b0}};
            paused_r     <= 1'b0;
            time_event_r <= 1'b0;
        end else begin
            prev_code_r <= code_s;
            if (resume_s) begin
                paused_r     <= 1'b0;
                time_event_r <= 1'b0;
            end else if (entry_s) begin
                rem_r        <= dur_s - ENTRY_ADJ;
                presc_r      <= PRESC_ENTRY;
                paused_r     <= 1'b0;
                time_event_r <= entry_event_s;
            end else if (paused_r) begin
                time_event_r <= 1'b0;
            end else if (code_s == PH_IDLE) begin
                rem_r        <= {SEC_W{1'b0}};
                presc_r      <= {PW{1'b0}};
                time_event_r <= 1'b0;
            end else if (pause_s) begin
                paused_r     <= 1'b1;
                time_event_r <= 1'b0;
            end else if (rem_r != {SEC_W{1'b0}}) begin
                time_event_r <= tick_s && (rem_r == SEC_W'(1'b1));
                if (tick_s) begin
                    presc_r <= {PW{1'b0}};
                    rem_r   <= rem_r - SEC_W'(1'b1);
                end else begin
                    presc_r <= presc_r + PW'(1'b1);
                end
            end else begin
                time_event_r <= 1'b0;
            end
        end
    end

    assign Time_Event    = time_event_r;
    assign Remaining_Sec = rem_r;
    assign Paused        = paused_r;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Table-driven bench for wash_phase_timer: per-cycle vectors through a scoreboard queue,
// plus a hand-written asynchronous reset sequence.
module tb_wash_phase_timer;

    localparam int SEC_W = 10;
    localparam int FILL  = 2;
    localparam int WASH  = 3;
    localparam int RINSE = 2;
    localparam int SPIN  = 3;
`ifdef WASH_TIMER_FAST_SIM_EN
    localparam int T = 1;
`else
    localparam int T = 4;
`endif

    logic             Clk_D = 1'b0;
    logic             Rst = 1'b0;
    logic [2:0]       Timer_Encoding = 3'd0;
    logic             Pause_Enable = 1'b0;
    logic             Time_Event;
    logic [SEC_W-1:0] Remaining_Sec;
    logic             Paused;

    wash_phase_timer #(
        .TICKS_PER_SEC(4), .FILL_SEC(FILL), .WASH_SEC(WASH),
        .RINSE_SEC(RINSE), .SPIN_SEC(SPIN), .SEC_W(SEC_W)
    ) dut (
        .Clk_D(Clk_D), .Rst(Rst), .Timer_Encoding(Timer_Encoding),
        .Pause_Enable(Pause_Enable), .Time_Event(Time_Event),
        .Remaining_Sec(Remaining_Sec), .Paused(Paused)
    );

    always #5 Clk_D = ~Clk_D;

    typedef struct {
        logic [2:0]       code;
        logic             pause;
        logic             te;
        logic [SEC_W-1:0] rem;
        logic             paused;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Seconds left j cycles after entry of a phase of dur seconds.
    function automatic int exp_rem_f(input int dur, input int j);
        if (j >= dur * T) return 0;
        return dur - j / T;
    endfunction

    task automatic add(input logic [2:0] code, input logic pause, input logic te,
                       input int rem, input logic paused);
        vec_t v;
        v.code = code; v.pause = pause; v.te = te; v.rem = SEC_W'(rem); v.paused = paused;
        vecs.push_back(v);
    endtask

    // Entry cycle (outputs still from before), then nj cycles of the phase.
    task automatic add_phase(input logic [2:0] code, input int dur, input int nj, input int pause_j,
                             input int e_rem, input logic e_te, input logic e_paused);
        add(code, 1'b0, e_te, e_rem, e_paused);
        for (int j = 1; j <= nj; j++)
            add(code, j == pause_j, j == dur * T, exp_rem_f(dur, j), 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    initial begin
        int fr;
        int jp;
        vec_t e;

        add(3'd0, 1'b0, 1'b0, 0, 1'b0);
        add(3'd0, 1'b0, 1'b0, 0, 1'b0);
        // Full cycle, each code advanced the cycle after its pulse; pause attempted on spin expiry.
        add_phase(3'd1, FILL, FILL * T, -1, 0, 1'b0, 1'b0);
        add_phase(3'd2, WASH, WASH * T, -1, 0, 1'b0, 1'b0);
        add_phase(3'd3, RINSE, RINSE * T, -1, 0, 1'b0, 1'b0);
        add_phase(3'd4, SPIN, SPIN * T + 2, SPIN * T, 0, 1'b0, 1'b0);
        add(3'd0, 1'b0, 1'b0, 0, 1'b0);
        add(3'd7, 1'b0, 1'b0, 0, 1'b0);
        add(3'd5, 1'b0, 1'b0, 0, 1'b0);
        add(3'd0, 1'b0, 1'b0, 0, 1'b0);
        // Abort washing into rinsing.
        add_phase(3'd2, WASH, T + 1, -1, 0, 1'b0, 1'b0);
        add_phase(3'd3, RINSE, RINSE * T + 1, -1, exp_rem_f(WASH, T + 2), 1'b0, 1'b0);
        add(3'd0, 1'b0, 1'b0, 0, 1'b0);
        // Pause spin, idle 20 cycles, resume.
        jp = T + 1;
        add_phase(3'd4, SPIN, jp, jp, 0, 1'b0, 1'b0);
        fr = exp_rem_f(SPIN, jp);
        add(3'd4, 1'b0, 1'b0, fr, 1'b1);
        for (int i = 0; i < 20; i++) add(3'd0, 1'b1, 1'b0, fr, 1'b1);
        add(3'd4, 1'b0, 1'b0, fr, 1'b1);
        for (int i = 1; i <= SPIN * T - jp + 2; i++)
            add(3'd4, 1'b0, (jp + i - 1) == SPIN * T, exp_rem_f(SPIN, jp + i - 1), 1'b0);
        add(3'd0, 1'b0, 1'b0, 0, 1'b0);
        // Pause spin, then go straight to filling: normal load, pause cleared.
        add_phase(3'd4, SPIN, 1, 1, 0, 1'b0, 1'b0);
        add_phase(3'd1, FILL, FILL * T, -1, exp_rem_f(SPIN, 1), 1'b0, 1'b1);
        add(3'd0, 1'b0, 1'b0, 0, 1'b0);
        add(3'd0, 1'b0, 1'b0, 0, 1'b0);

        #12;
        chk("reset_te", 32'(Time_Event), 32'd0);
        chk("reset_rem", 32'(Remaining_Sec), 32'd0);
        chk("reset_paused", 32'(Paused), 32'd0);
        @(negedge Clk_D);
        Rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge Clk_D);
            #1;
            Timer_Encoding = vecs[i].code;
            Pause_Enable   = vecs[i].pause;
            exp_q.push_back(vecs[i]);
            @(negedge Clk_D);
            e = exp_q.pop_front();
            chk($sformatf("te[%0d]", i), 32'(Time_Event), 32'(e.te));
            chk($sformatf("rem[%0d]", i), 32'(Remaining_Sec), 32'(e.rem));
            chk($sformatf("paused[%0d]", i), 32'(Paused), 32'(e.paused));
        end

        // Asynchronous reset mid-washing, then a fresh entry.
        @(posedge Clk_D);
        #1;
        Timer_Encoding = 3'd2;
        Pause_Enable   = 1'b0;
        repeat (T + 2) @(posedge Clk_D);
        #2;
        chk("pre_rst_rem", 32'(Remaining_Sec), 32'(exp_rem_f(WASH, T + 2)));
        Rst = 1'b0;
        #1;
        chk("mid_rst_te", 32'(Time_Event), 32'd0);
        chk("mid_rst_rem", 32'(Remaining_Sec), 32'd0);
        chk("mid_rst_paused", 32'(Paused), 32'd0);
        @(negedge Clk_D);
        Rst = 1'b1;
        @(negedge Clk_D);
        chk("post_rst_load", 32'(Remaining_Sec), 32'(exp_rem_f(WASH, 1)));
        repeat (T) @(negedge Clk_D);
        chk("post_rst_count", 32'(Remaining_Sec), 32'(exp_rem_f(WASH, T + 1)));
        chk("post_rst_te", 32'(Time_Event), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
